// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage, the later pipeline stages and the ID->EX register.
// The slave modport is the pipeline register. The master modport is whoever drives it.
interface id_ex_stage_if #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 32
);
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              id_use1;
  logic              id_use2;
  logic [4:0]        id_rd;
  logic              id_wr;
  logic              id_is_load;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       rf_a;
  logic [31:0]       rf_b;
  logic              mem_valid;
  logic              mem_wr;
  logic              mem_is_load;
  logic [4:0]        mem_rd;
  logic [31:0]       mem_data;
  logic              wb_valid;
  logic              wb_wr;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              ex_ready;
  logic              flush;
  logic              id_stall;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_a;
  logic [31:0]       ex_b;
  logic [4:0]        ex_rd;
  logic              ex_wr;
  logic              ex_is_load;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wr, id_is_load,
           id_ctrl, rf_a, rf_b, mem_valid, mem_wr, mem_is_load, mem_rd, mem_data,
           wb_valid, wb_wr, wb_rd, wb_data, ex_ready, flush,
    input  id_stall, ex_valid, ex_pc, ex_a, ex_b, ex_rd, ex_wr, ex_is_load, ex_ctrl,
           stall_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wr, id_is_load,
           id_ctrl, rf_a, rf_b, mem_valid, mem_wr, mem_is_load, mem_rd, mem_data,
           wb_valid, wb_wr, wb_rd, wb_data, ex_ready, flush,
    output id_stall, ex_valid, ex_pc, ex_a, ex_b, ex_rd, ex_wr, ex_is_load, ex_ctrl,
           stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with RAW hazard stall, MEM/WB operand forwarding and a
// saturating counter of ID stall cycles.
module id_ex_stage #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  logic              ex_valid_q, ex_valid_d;
  logic [31:0]       ex_pc_q, ex_pc_d;
  logic [31:0]       ex_a_q, ex_a_d;
  logic [31:0]       ex_b_q, ex_b_d;
  logic [4:0]        ex_rd_q, ex_rd_d;
  logic              ex_wr_q, ex_wr_d;
  logic              ex_is_load_q, ex_is_load_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic ex_hit, mem_hit, hazard, id_stall;
  logic mem_fwd_en, wb_fwd_en;

  // A load still in MEM has no data yet, so only loads count as MEM-stage hazards.
  assign ex_hit = ex_valid_q & ex_wr_q & (ex_rd_q != 5'd0) &
                  ((bus.id_use1 & (bus.id_rs1 == ex_rd_q)) |
                   (bus.id_use2 & (bus.id_rs2 == ex_rd_q)));
  assign mem_hit = bus.mem_valid & bus.mem_wr & bus.mem_is_load & (bus.mem_rd != 5'd0) &
                   ((bus.id_use1 & (bus.id_rs1 == bus.mem_rd)) |
                    (bus.id_use2 & (bus.id_rs2 == bus.mem_rd)));
  assign hazard   = bus.id_valid & (ex_hit | mem_hit);
  assign id_stall = ~rst & ~bus.flush & (hazard | ~bus.ex_ready);

  assign mem_fwd_en = bus.mem_valid & bus.mem_wr & ~bus.mem_is_load;
  assign wb_fwd_en  = bus.wb_valid & bus.wb_wr;

  function automatic logic [31:0] fwd_sel(input logic [4:0]  rs,
                                          input logic [31:0] rf,
                                          input logic        m_en,
                                          input logic [4:0]  m_rd,
                                          input logic [31:0] m_data,
                                          input logic        w_en,
                                          input logic [4:0]  w_rd,
                                          input logic [31:0] w_data);
    logic [31:0] val;
    val = rf;
    if (rs == 5'd0) begin
      val = 32'd0;
    end else if (m_en && (m_rd == rs)) begin
      val = m_data;
    end else if (w_en && (w_rd == rs)) begin
      val = w_data;
    end
    return val;
  endfunction

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_a_d       = ex_a_q;
    ex_b_d       = ex_b_q;
    ex_rd_d      = ex_rd_q;
    ex_wr_d      = ex_wr_q;
    ex_is_load_d = ex_is_load_q;
    ex_ctrl_d    = ex_ctrl_q;
    if (bus.flush) begin
      ex_valid_d   = 1'b0;
      ex_wr_d      = 1'b0;
      ex_is_load_d = 1'b0;
    end else if (!bus.ex_ready) begin
      // hold: defaults already keep every field
    end else if (hazard) begin
      ex_valid_d   = 1'b0;
      ex_wr_d      = 1'b0;
      ex_is_load_d = 1'b0;
    end else begin
      ex_valid_d   = bus.id_valid;
      ex_pc_d      = bus.id_pc;
      ex_a_d       = fwd_sel(bus.id_rs1, bus.rf_a, mem_fwd_en, bus.mem_rd, bus.mem_data,
                             wb_fwd_en, bus.wb_rd, bus.wb_data);
      ex_b_d       = fwd_sel(bus.id_rs2, bus.rf_b, mem_fwd_en, bus.mem_rd, bus.mem_data,
                             wb_fwd_en, bus.wb_rd, bus.wb_data);
      ex_rd_d      = bus.id_rd;
      ex_wr_d      = bus.id_valid & bus.id_wr;
      ex_is_load_d = bus.id_valid & bus.id_is_load;
      ex_ctrl_d    = bus.id_ctrl;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.id_valid && id_stall && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_rd_q      <= '0;
      ex_wr_q      <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_ctrl_q    <= '0;
      cnt_q        <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_rd_q      <= ex_rd_d;
      ex_wr_q      <= ex_wr_d;
      ex_is_load_q <= ex_is_load_d;
      ex_ctrl_q    <= ex_ctrl_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.id_stall   = id_stall;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_pc      = ex_pc_q;
  assign bus.ex_a       = ex_a_q;
  assign bus.ex_b       = ex_b_q;
  assign bus.ex_rd      = ex_rd_q;
  assign bus.ex_wr      = ex_wr_q;
  assign bus.ex_is_load = ex_is_load_q;
  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/forwarding scenarios followed by random traffic,
// all checked against a cycle-level reference model of the stage's rules.
module tb_id_ex_stage;
  localparam int unsigned CTRL_W  = 16;
  localparam int unsigned CNT_W   = 6;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the EX register contents.
  bit                m_valid, m_wr, m_load, m_side_known;
  logic [31:0]       m_pc, m_a, m_b;
  logic [4:0]        m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reads_reg(input logic [4:0] r);
    return (r != 0) && ((bus.id_use1 && bus.id_rs1 == r) || (bus.id_use2 && bus.id_rs2 == r));
  endfunction

  function automatic bit model_hazard();
    bit on_ex, on_mem;
    on_ex  = m_valid && m_wr && reads_reg(m_rd);
    on_mem = bus.mem_valid && bus.mem_wr && bus.mem_is_load && reads_reg(bus.mem_rd);
    return bus.id_valid && (on_ex || on_mem);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 32'd0;
    if (bus.mem_valid && bus.mem_wr && !bus.mem_is_load && bus.mem_rd == rs) return bus.mem_data;
    if (bus.wb_valid && bus.wb_wr && bus.wb_rd == rs) return bus.wb_data;
    return rf;
  endfunction

  task automatic idle();
    rst = 1'b0;
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_use1 = 0; bus.id_use2 = 0; bus.id_rd = 0; bus.id_wr = 0; bus.id_is_load = 0;
    bus.id_ctrl = 0; bus.rf_a = 0; bus.rf_b = 0;
    bus.mem_valid = 0; bus.mem_wr = 0; bus.mem_is_load = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.wb_valid = 0; bus.wb_wr = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.ex_ready = 1; bus.flush = 0;
  endtask

  // One clock: check id_stall, advance model and DUT, compare registered outputs.
  task automatic step();
    bit hz, exp_stall;
    #1;
    hz        = model_hazard();
    exp_stall = !rst && !bus.flush && (hz || !bus.ex_ready);
    check("id_stall", {31'd0, bus.id_stall}, {31'd0, exp_stall});
    if (rst) begin
      m_valid = 0; m_wr = 0; m_load = 0; m_side_known = 1;
      m_pc = 0; m_a = 0; m_b = 0; m_rd = 0; m_ctrl = 0; m_cnt = 0;
    end else begin
      if (bus.id_valid && exp_stall && m_cnt < CNT_MAX) m_cnt++;
      if (bus.flush) begin
        m_valid = 0; m_side_known = 0;
      end else if (!bus.ex_ready) begin
        // held
      end else if (hz) begin
        m_valid = 0; m_wr = 0; m_load = 0; m_side_known = 1;
      end else begin
        m_valid = bus.id_valid;
        m_pc    = bus.id_pc;
        m_a     = operand(bus.id_rs1, bus.rf_a);
        m_b     = operand(bus.id_rs2, bus.rf_b);
        m_rd    = bus.id_rd;
        m_ctrl  = bus.id_ctrl;
        m_wr    = bus.id_valid && bus.id_wr;
        m_load  = bus.id_valid && bus.id_is_load;
        m_side_known = 1;
      end
    end
    @(posedge clk);
    #1;
    check("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_valid});
    check("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
    if (m_side_known) begin
      check("ex_wr", {31'd0, bus.ex_wr}, {31'd0, m_wr});
      check("ex_is_load", {31'd0, bus.ex_is_load}, {31'd0, m_load});
    end
    if (m_valid) begin
      check("ex_pc", bus.ex_pc, m_pc);
      check("ex_a", bus.ex_a, m_a);
      check("ex_b", bus.ex_b, m_b);
      check("ex_rd", {27'd0, bus.ex_rd}, {27'd0, m_rd});
      check("ex_ctrl", 32'(bus.ex_ctrl), 32'(m_ctrl));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    idle();
  endtask

  initial begin
    idle();
    @(negedge clk);

    // T1: reset
    do_reset();
    check("t1_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("t1_ex_a", bus.ex_a, 32'd0);
    check("t1_ex_b", bus.ex_b, 32'd0);
    check("t1_cnt", 32'(bus.stall_cnt), 32'd0);
    check("t1_stall", {31'd0, bus.id_stall}, 32'd0);

    // T2: ALU RAW, one bubble, then MEM forwarding
    bus.id_valid = 1; bus.id_wr = 1; bus.id_rd = 5; bus.id_pc = 32'h100; bus.id_ctrl = 16'h0013;
    step();
    bus.id_pc = 32'h104; bus.id_rd = 7; bus.id_use1 = 1; bus.id_rs1 = 5; bus.rf_a = 32'h1111;
    #1 check("t2_stall", {31'd0, bus.id_stall}, 32'd1);
    step();
    check("t2_bubble", {31'd0, bus.ex_valid}, 32'd0);
    bus.mem_valid = 1; bus.mem_wr = 1; bus.mem_rd = 5; bus.mem_data = 32'h1234;
    step();
    check("t2_fwd", bus.ex_a, 32'h1234);
    check("t2_cnt", 32'(bus.stall_cnt), 32'd1);

    // T3: load-use, two bubbles, then WB forwarding into rs2
    do_reset();
    bus.id_valid = 1; bus.id_wr = 1; bus.id_is_load = 1; bus.id_rd = 6; bus.id_pc = 32'h200;
    step();
    bus.id_is_load = 0; bus.id_rd = 8; bus.id_use2 = 1; bus.id_rs2 = 6; bus.rf_b = 32'h2222;
    bus.id_pc = 32'h204;
    step();
    bus.mem_valid = 1; bus.mem_wr = 1; bus.mem_is_load = 1; bus.mem_rd = 6;
    step();
    check("t3_bubble2", {31'd0, bus.ex_valid}, 32'd0);
    bus.mem_valid = 0; bus.wb_valid = 1; bus.wb_wr = 1; bus.wb_rd = 6; bus.wb_data = 32'hDEADBEEF;
    step();
    check("t3_fwd", bus.ex_b, 32'hDEADBEEF);
    check("t3_cnt", 32'(bus.stall_cnt), 32'd2);

    // T4: MEM beats WB; x0 never forwarded
    do_reset();
    bus.id_valid = 1; bus.id_use1 = 1; bus.id_rs1 = 3; bus.rf_a = 32'h7;
    bus.mem_valid = 1; bus.mem_wr = 1; bus.mem_rd = 3; bus.mem_data = 32'hA;
    bus.wb_valid = 1; bus.wb_wr = 1; bus.wb_rd = 3; bus.wb_data = 32'hB;
    step();
    check("t4_prio", bus.ex_a, 32'hA);
    bus.id_rs1 = 0; bus.mem_rd = 0; bus.mem_data = 32'h55; bus.wb_rd = 0; bus.rf_a = 32'h99;
    step();
    check("t4_x0", bus.ex_a, 32'd0);

    // T5: flush wins over ~ex_ready and a hazard
    do_reset();
    bus.id_valid = 1; bus.id_wr = 1; bus.id_rd = 5;
    step();
    bus.id_use1 = 1; bus.id_rs1 = 5; bus.ex_ready = 0; bus.flush = 1;
    #1 check("t5_stall", {31'd0, bus.id_stall}, 32'd0);
    step();
    check("t5_valid", {31'd0, bus.ex_valid}, 32'd0);

    // T6: ex_ready low holds EX and stalls; long stall saturates the counter
    do_reset();
    bus.id_valid = 1; bus.id_pc = 32'h300; bus.id_rd = 9; bus.id_wr = 1;
    step();
    bus.ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.id_pc = 32'h400 + 32'(i);
      step();
    end
    check("t6_hold_pc", bus.ex_pc, 32'h300);
    check("t6_cnt3", 32'(bus.stall_cnt), 32'd3);
    for (int i = 0; i < CNT_MAX + 5; i++) step();
    check("t6_sat", 32'(bus.stall_cnt), 32'(CNT_MAX));

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      bus.id_valid   = ($urandom_range(0, 4) != 0);
      bus.id_pc      = $urandom;
      bus.id_rs1     = 5'($urandom_range(0, 3));
      bus.id_rs2     = 5'($urandom_range(0, 3));
      bus.id_use1    = 1'($urandom);
      bus.id_use2    = 1'($urandom);
      bus.id_rd      = 5'($urandom_range(0, 3));
      bus.id_wr      = 1'($urandom);
      bus.id_is_load = 1'($urandom);
      bus.id_ctrl    = 16'($urandom);
      bus.rf_a       = $urandom;
      bus.rf_b       = $urandom;
      bus.mem_valid  = 1'($urandom);
      bus.mem_wr     = 1'($urandom);
      bus.mem_is_load = 1'($urandom);
      bus.mem_rd     = 5'($urandom_range(0, 3));
      bus.mem_data   = $urandom;
      bus.wb_valid   = 1'($urandom);
      bus.wb_wr      = 1'($urandom);
      bus.wb_rd      = 5'($urandom_range(0, 3));
      bus.wb_data    = $urandom;
      bus.ex_ready   = ($urandom_range(0, 3) != 0);
      bus.flush      = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
